// File: rtl/rv32m_mul_issue.sv
// RV32M multiply issue stage: decodes funct3, feeds unsigned magnitudes to the multiplier, sign-corrects and returns the result.
// Optional macro RV32M_MUL_ZERO_BYPASS_EN: zero operands answer directly from IDLE without running the multiplier.
module rv32m_mul_issue #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_rs1_i,
  input  logic [31:0] req_rs2_i,
  input  logic [4:0]  req_rd_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_data_o,
  output logic [4:0]  resp_rd_o,
  output logic        resp_err_o,
  output logic        busy_o,
  output logic        mult_rst_o,
  output logic        mult_en_o,
  output logic [31:0] mult_a_o,
  output logic [31:0] mult_b_o,
  input  logic        mult_done_i,
  input  logic [63:0] mult_prod_i
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 32'd1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_FIX   = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t            state_r, state_s;
  logic [2:0]        funct3_r, funct3_s;
  logic              neg_r, neg_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [63:0]       prod_r, prod_s;
  logic [63:0]       fixed_s;
  logic              resp_valid_r, resp_valid_s;
  logic [31:0]       resp_data_r, resp_data_s;
  logic [4:0]        resp_rd_r, resp_rd_s;
  logic              resp_err_r, resp_err_s;
  logic              busy_r;
  logic              mult_rst_r, mult_rst_s;
  logic              mult_en_r, mult_en_s;
  logic [31:0]       mult_a_r, mult_a_s;
  logic [31:0]       mult_b_r, mult_b_s;
  logic              sa_s, sb_s;

  // MULH/MULHSU treat rs1 as signed; only MULH treats rs2 as signed
  assign sa_s = ((req_funct3_i == 3'b001) || (req_funct3_i == 3'b010)) && req_rs1_i[31];
  assign sb_s = (req_funct3_i == 3'b001) && req_rs2_i[31];
  assign fixed_s = neg_r ? (~prod_r + 64'd1) : prod_r;

  // Next-state and next-output decode
  always_comb begin
    state_s      = state_r;
    funct3_s     = funct3_r;
    neg_s        = neg_r;
    cnt_s        = cnt_r;
    prod_s       = prod_r;
    resp_valid_s = resp_valid_r;
    resp_data_s  = resp_data_r;
    resp_rd_s    = resp_rd_r;
    resp_err_s   = resp_err_r;
    mult_rst_s   = 1'b0;
    mult_en_s    = 1'b0;
    mult_a_s     = mult_a_r;
    mult_b_s     = mult_b_r;
    case (state_r)
      S_IDLE: begin
        if (req_valid_i) begin
          funct3_s  = req_funct3_i;
          resp_rd_s = req_rd_i;
          mult_a_s  = sa_s ? (32'd0 - req_rs1_i) : req_rs1_i;
          mult_b_s  = sb_s ? (32'd0 - req_rs2_i) : req_rs2_i;
          neg_s     = sa_s ^ sb_s;
          cnt_s     = '0;
          if (req_funct3_i[2]) begin
            state_s      = S_RESP;
            resp_valid_s = 1'b1;
            resp_err_s   = 1'b1;
            resp_data_s  = 32'd0;
`ifdef RV32M_MUL_ZERO_BYPASS_EN
          end else if ((req_rs1_i == 32'd0) || (req_rs2_i == 32'd0)) begin
            state_s      = S_RESP;
            resp_valid_s = 1'b1;
            resp_err_s   = 1'b0;
            resp_data_s  = 32'd0;
`endif
          end else begin
            state_s    = S_CLEAR;
            mult_rst_s = 1'b1;
            resp_err_s = 1'b0;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_CLEAR: begin
        state_s   = S_RUN;
        mult_en_s = 1'b1;
        cnt_s     = '0;
      end
      S_RUN: begin
        if (mult_done_i) begin
          prod_s  = mult_prod_i;
          state_s = S_FIX;
        end else if (cnt_r == CNT_LAST) begin
          // Abandon the stuck multiplier: report an error and clear it
          state_s      = S_RESP;
          resp_valid_s = 1'b1;
          resp_err_s   = 1'b1;
          resp_data_s  = 32'd0;
          mult_rst_s   = 1'b1;
        end else begin
          mult_en_s = 1'b1;
          cnt_s     = cnt_r + CNT_W'(1);
        end
      end
      S_FIX: begin
        state_s      = S_RESP;
        resp_valid_s = 1'b1;
        resp_err_s   = 1'b0;
        resp_data_s  = (funct3_r == 3'b000) ? fixed_s[31:0] : fixed_s[63:32];
      end
      S_RESP: begin
        if (resp_ready_i) begin
          state_s      = S_IDLE;
          resp_valid_s = 1'b0;
        end else begin
          state_s = S_RESP;
        end
      end
      default: begin
        state_s      = S_IDLE;
        resp_valid_s = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r      <= S_IDLE;
      funct3_r     <= 3'd0;
      neg_r        <= 1'b0;
      cnt_r        <= '0;
      prod_r       <= 64'd0;
      resp_valid_r <= 1'b0;
      resp_data_r  <= 32'd0;
      resp_rd_r    <= 5'd0;
      resp_err_r   <= 1'b0;
      busy_r       <= 1'b0;
      mult_rst_r   <= 1'b1;
      mult_en_r    <= 1'b0;
      mult_a_r     <= 32'd0;
      mult_b_r     <= 32'd0;
    end else begin
      state_r      <= state_s;
      funct3_r     <= funct3_s;
      neg_r        <= neg_s;
      cnt_r        <= cnt_s;
      prod_r       <= prod_s;
      resp_valid_r <= resp_valid_s;
      resp_data_r  <= resp_data_s;
      resp_rd_r    <= resp_rd_s;
      resp_err_r   <= resp_err_s;
      busy_r       <= (state_s != S_IDLE);
      mult_rst_r   <= mult_rst_s;
      mult_en_r    <= mult_en_s;
      mult_a_r     <= mult_a_s;
      mult_b_r     <= mult_b_s;
    end
  end

  assign req_ready_o  = (state_r == S_IDLE);
  assign resp_valid_o = resp_valid_r;
  assign resp_data_o  = resp_data_r;
  assign resp_rd_o    = resp_rd_r;
  assign resp_err_o   = resp_err_r;
  assign busy_o       = busy_r;
  // Keep the multiplier cleared for as long as reset is held
  assign mult_rst_o   = mult_rst_r | ~rst_ni;
  assign mult_en_o    = mult_en_r;
  assign mult_a_o     = mult_a_r;
  assign mult_b_o     = mult_b_r;

endmodule

// File: tb/tb_rv32m_mul_issue.sv
// Directed table-driven bench for rv32m_mul_issue with a small behavioural multiplier (done 6 cycles after clear).
module tb_rv32m_mul_issue;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [2:0]  req_funct3_i = 3'd0;
  logic [31:0] req_rs1_i = 32'd0;
  logic [31:0] req_rs2_i = 32'd0;
  logic [4:0]  req_rd_i = 5'd0;
  logic        resp_valid_o;
  logic        resp_ready_i = 1'b0;
  logic [31:0] resp_data_o;
  logic [4:0]  resp_rd_o;
  logic        resp_err_o;
  logic        busy_o;
  logic        mult_rst_o;
  logic        mult_en_o;
  logic [31:0] mult_a_o;
  logic [31:0] mult_b_o;
  logic        mult_done_i;
  logic [63:0] mult_prod_i;

  logic        m_done = 1'b0;
  logic [2:0]  m_cnt = 3'd0;
  logic [63:0] m_prod = 64'd0;
  logic        mult_stall = 1'b0;

  int checks = 0;
  int errors = 0;

`ifdef RV32M_MUL_ZERO_BYPASS_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 10;
`endif

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    bit          stall;
  } vec_t;

  vec_t vecs[12];

  rv32m_mul_issue #(.TIMEOUT_CYCLES(15)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_funct3_i(req_funct3_i), .req_rs1_i(req_rs1_i), .req_rs2_i(req_rs2_i), .req_rd_i(req_rd_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_data_o(resp_data_o), .resp_rd_o(resp_rd_o), .resp_err_o(resp_err_o),
    .busy_o(busy_o), .mult_rst_o(mult_rst_o), .mult_en_o(mult_en_o),
    .mult_a_o(mult_a_o), .mult_b_o(mult_b_o),
    .mult_done_i(mult_done_i), .mult_prod_i(mult_prod_i)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural multiplier: cleared by mult_rst_o, raises done on the 6th enabled edge
  always @(posedge clk_i) begin
    if (mult_rst_o) begin
      m_cnt  <= 3'd0;
      m_done <= 1'b0;
      m_prod <= 64'd0;
    end else if (mult_en_o && !m_done) begin
      if (m_cnt == 3'd5) begin
        m_done <= 1'b1;
        m_prod <= {32'd0, mult_a_o} * {32'd0, mult_b_o};
      end else begin
        m_cnt <= m_cnt + 3'd1;
      end
    end
  end

  assign mult_done_i = m_done & ~mult_stall;
  assign mult_prod_i = m_prod;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one request (caller is at a negedge), track it to the response, hold it, then accept it
  task automatic run_vec(input vec_t v, input int hold);
    int  n;
    bit  got;
    bit  en_seen;
    bit  rst_seen;
    check("req_ready_idle", 64'(req_ready_o), 64'd1);
    mult_stall   = v.stall;
    req_valid_i  = 1'b1;
    req_funct3_i = v.f3;
    req_rs1_i    = v.rs1;
    req_rs2_i    = v.rs2;
    req_rd_i     = v.rd;
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    n = 0; got = 1'b0; en_seen = 1'b0; rst_seen = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk_i);
      n++;
      if (mult_en_o) en_seen = 1'b1;
      if (mult_rst_o && !v.stall) rst_seen = 1'b1;
      if (n == 2 && v.exp_lat >= 10) begin
        check("mult_a", 64'(mult_a_o), 64'(v.exp_a));
        check("mult_b", 64'(mult_b_o), 64'(v.exp_b));
        check("mult_en_run", 64'(mult_en_o), 64'd1);
      end
      if (resp_valid_o) got = 1'b1;
    end
    check("resp_latency", 64'(n), 64'(v.exp_lat));
    check("resp_data", 64'(resp_data_o), 64'(v.exp_data));
    check("resp_err", 64'(resp_err_o), 64'(v.exp_err));
    check("resp_rd", 64'(resp_rd_o), 64'(v.rd));
    check("req_ready_busy", 64'(req_ready_o), 64'd0);
    if (v.stall) check("timeout_mult_rst", 64'(mult_rst_o), 64'd1);
    if (v.exp_lat < 10) begin
      check("no_mult_en", 64'(en_seen), 64'd0);
      check("no_mult_rst", 64'(rst_seen), 64'd0);
    end
    for (int k = 0; k < hold; k++) begin
      @(negedge clk_i);
      check("hold_valid", 64'(resp_valid_o), 64'd1);
      check("hold_data", 64'(resp_data_o), 64'(v.exp_data));
      check("hold_rd", 64'(resp_rd_o), 64'(v.rd));
      check("hold_ready", 64'(req_ready_o), 64'd0);
    end
    resp_ready_i = 1'b1;
    @(posedge clk_i);
    #1 resp_ready_i = 1'b0;
    mult_stall = 1'b0;
    @(negedge clk_i);
    check("resp_drop", 64'(resp_valid_o), 64'd0);
    check("idle_busy", 64'(busy_o), 64'd0);
  endtask

  initial begin
    vec_t bp;
    vec_t b2b;
    vec_t rv;
    int   late;
    //        f3      rs1            rs2            rd     data           err  lat   a              b              stall
    vecs[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 1'b0, 10,   32'h0000_0007, 32'hFFFF_FFFD, 1'b0};
    vecs[1]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1,  32'h4000_0000, 1'b0, 10,   32'h8000_0000, 32'h8000_0000, 1'b0};
    vecs[2]  = '{3'b011, 32'h8000_0000, 32'h8000_0000, 5'd2,  32'h4000_0000, 1'b0, 10,   32'h8000_0000, 32'h8000_0000, 1'b0};
    vecs[3]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF, 1'b0, 10,   32'h0000_0001, 32'hFFFF_FFFF, 1'b0};
    vecs[4]  = '{3'b001, 32'hFFFF_FFFE, 32'h0000_0003, 5'd4,  32'hFFFF_FFFF, 1'b0, 10,   32'h0000_0002, 32'h0000_0003, 1'b0};
    vecs[5]  = '{3'b000, 32'hFFFF_FFFE, 32'h0000_0003, 5'd6,  32'hFFFF_FFFA, 1'b0, 10,   32'hFFFF_FFFE, 32'h0000_0003, 1'b0};
    vecs[6]  = '{3'b001, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd8,  32'h3FFF_FFFF, 1'b0, 10,   32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0};
    vecs[7]  = '{3'b100, 32'h0000_0009, 32'h0000_0009, 5'd7,  32'h0000_0000, 1'b1, 1,    32'h0000_0009, 32'h0000_0009, 1'b0};
    vecs[8]  = '{3'b111, 32'h0000_0009, 32'h0000_0009, 5'd31, 32'h0000_0000, 1'b1, 1,    32'h0000_0009, 32'h0000_0009, 1'b0};
    vecs[9]  = '{3'b000, 32'h0000_0000, 32'h0000_0005, 5'd9,  32'h0000_0000, 1'b0, ZLAT, 32'h0000_0000, 32'h0000_0005, 1'b0};
    vecs[10] = '{3'b001, 32'h0000_0005, 32'hFFFF_FFFB, 5'd10, 32'hFFFF_FFFF, 1'b0, 10,   32'h0000_0005, 32'h0000_0005, 1'b0};
    vecs[11] = '{3'b000, 32'h0000_0003, 32'h0000_0004, 5'd11, 32'h0000_0000, 1'b1, 17,   32'h0000_0003, 32'h0000_0004, 1'b1};

    // Reset state
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_resp_valid", 64'(resp_valid_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_mult_en", 64'(mult_en_o), 64'd0);
    check("rst_mult_rst", 64'(mult_rst_o), 64'd1);
    check("rst_data", 64'(resp_data_o), 64'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("idle_mult_rst", 64'(mult_rst_o), 64'd0);
    check("idle_ready", 64'(req_ready_o), 64'd1);

    for (int i = 0; i < 12; i++) run_vec(vecs[i], 0);

    // Backpressure for 5 cycles, then an immediate back-to-back MULHU
    bp  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd12, 32'hFFFF_FFEB, 1'b0, 10, 32'h0000_0007, 32'hFFFF_FFFD, 1'b0};
    b2b = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13, 32'hFFFF_FFFE, 1'b0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
    run_vec(bp, 5);
    run_vec(b2b, 0);

    // Reset while in RUN discards the request
    req_valid_i  = 1'b1;
    req_funct3_i = 3'b001;
    req_rs1_i    = 32'h1234_5678;
    req_rs2_i    = 32'h0000_0010;
    req_rd_i     = 5'd21;
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    repeat (4) @(negedge clk_i);
    check("pre_rst_run", 64'(mult_en_o), 64'd1);
    rst_ni = 1'b0;
    @(negedge clk_i);
    check("mid_rst_valid", 64'(resp_valid_o), 64'd0);
    check("mid_rst_err", 64'(resp_err_o), 64'd0);
    check("mid_rst_busy", 64'(busy_o), 64'd0);
    check("mid_rst_en", 64'(mult_en_o), 64'd0);
    check("mid_rst_data", 64'(resp_data_o), 64'd0);
    check("mid_rst_rd", 64'(resp_rd_o), 64'd0);
    check("mid_rst_a", 64'(mult_a_o), 64'd0);
    check("mid_rst_b", 64'(mult_b_o), 64'd0);
    check("mid_rst_mult_rst", 64'(mult_rst_o), 64'd1);
    rst_ni = 1'b1;
    late = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_i);
      if (resp_valid_o) late++;
    end
    check("no_resp_after_rst", 64'(late), 64'd0);

    // Recovery after reset: one more full multiply
    rv = '{3'b000, 32'h1234_5678, 32'h0000_0010, 5'd22, 32'h2345_6780, 1'b0, 10, 32'h1234_5678, 32'h0000_0010, 1'b0};
    run_vec(rv, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
